// File: rtl/heap_alloc_arbiter_if.sv
// Client request/response and RAM-side signals of the heap allocator, grouped for one port.
// master = client/RAM side (drives requests and ram_q), slave = the arbiter.
interface heap_alloc_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        alloc_req;
  logic [NUM_REQ-1:0]        free_req;
  logic [NUM_REQ*ADDR_W-1:0] free_addr;
  logic [NUM_REQ-1:0]        grant;
  logic                      done;
  logic                      ok;
  logic [ADDR_W-1:0]         result_addr;
  logic                      busy;
  logic [ADDR_W-1:0]         ram_address;
  logic [DATA_W-1:0]         ram_data;
  logic                      ram_wren;
  logic [DATA_W-1:0]         ram_q;

  modport master (
    output alloc_req, free_req, free_addr, ram_q,
    input  grant, done, ok, result_addr, busy, ram_address, ram_data, ram_wren
  );

  modport slave (
    input  alloc_req, free_req, free_addr, ram_q,
    output grant, done, ok, result_addr, busy, ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/heap_alloc_arbiter.sv
// Round-robin alloc/free arbiter owning the block-header heap in a single-port RAM.
// Latency: alloc 3k+2 (block k), full heap 3*(NUM_BLOCKS-1)+1, free 5/4/1; requests wait while busy.
module heap_alloc_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int BLOCK_STRIDE = 32
) (
  input logic                 clock,
  input logic                 resetn,
  heap_alloc_arbiter_if.slave bus_io
);

  localparam int SH         = $clog2(BLOCK_STRIDE);
  localparam int BI_W       = ADDR_W - SH;
  localparam int NUM_BLOCKS = (2 ** ADDR_W) / BLOCK_STRIDE;
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [BI_W-1:0] LAST_BLK = BI_W'(NUM_BLOCKS - 1);
  localparam logic [BI_W-1:0] FIRST_BLK = BI_W'(1);

  typedef enum logic [3:0] {
    CLEAR, IDLE, SCAN_RD, SCAN_WAIT, SCAN_CHK, MARK,
    FREE_RD, FREE_WAIT, FREE_CHK, FREE_WR, RESP
  } state_e;

  state_e              state_q;
  logic [BI_W-1:0]     ptr_q;
  logic [ID_W-1:0]     rr_q;
  logic [ID_W-1:0]     id_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic                done_q;
  logic                ok_q;
  logic [ADDR_W-1:0]   res_q;

  logic [NUM_REQ-1:0]  any_req;
  logic [ADDR_W-1:0]   faddr [NUM_REQ];
  logic [ID_W-1:0]     cand;
  logic                pick_vld;
  logic [ID_W-1:0]     pick_id;
  logic                pick_alloc;
  logic [ADDR_W-1:0]   pick_addr;
  logic                pick_free_ok;
  logic [ADDR_W-1:0]   blk_addr;
  logic                hdr_used;
  logic                unused_ram_bits;

  assign any_req         = bus_io.alloc_req | bus_io.free_req;
  assign blk_addr        = {ptr_q, {SH{1'b0}}};
  assign hdr_used        = bus_io.ram_q[DATA_W-1];
  assign unused_ram_bits = ^bus_io.ram_q[DATA_W-2:0];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      faddr[i] = bus_io.free_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Search starts one past the last granted client so every requester is reached in turn.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = rr_q;
    cand     = rr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_q) + i) % NUM_REQ);
      if (!pick_vld && any_req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
    pick_alloc   = bus_io.alloc_req[pick_id];
    pick_addr    = faddr[pick_id];
    pick_free_ok = (pick_addr[SH-1:0] == '0) && (pick_addr[ADDR_W-1:SH] != '0);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= CLEAR;
      ptr_q   <= FIRST_BLK;
      rr_q    <= '0;
      id_q    <= '0;
      grant_q <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      grant_q <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      res_q   <= '0;
      case (state_q)
        CLEAR: begin
          if (ptr_q == LAST_BLK) state_q <= IDLE;
          else                   ptr_q   <= ptr_q + 1'b1;
        end
        IDLE: begin
          if (pick_vld) begin
            id_q <= pick_id;
            if (pick_alloc) begin
              ptr_q   <= FIRST_BLK;
              state_q <= SCAN_RD;
            end else if (pick_free_ok) begin
              ptr_q   <= pick_addr[ADDR_W-1:SH];
              state_q <= FREE_RD;
            end else begin
              grant_q <= NUM_REQ'(1) << pick_id;
              done_q  <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        SCAN_RD:   state_q <= SCAN_WAIT;
        SCAN_WAIT: state_q <= SCAN_CHK;
        SCAN_CHK: begin
          if (!hdr_used) begin
            state_q <= MARK;
          end else if (ptr_q == LAST_BLK) begin
            grant_q <= NUM_REQ'(1) << id_q;
            done_q  <= 1'b1;
            state_q <= RESP;
          end else begin
            ptr_q   <= ptr_q + 1'b1;
            state_q <= SCAN_RD;
          end
        end
        MARK: begin
          grant_q <= NUM_REQ'(1) << id_q;
          done_q  <= 1'b1;
          ok_q    <= 1'b1;
          res_q   <= blk_addr;
          state_q <= RESP;
        end
        FREE_RD:   state_q <= FREE_WAIT;
        FREE_WAIT: state_q <= FREE_CHK;
        FREE_CHK: begin
          if (hdr_used) begin
            state_q <= FREE_WR;
          end else begin
            grant_q <= NUM_REQ'(1) << id_q;
            done_q  <= 1'b1;
            state_q <= RESP;
          end
        end
        FREE_WR: begin
          grant_q <= NUM_REQ'(1) << id_q;
          done_q  <= 1'b1;
          ok_q    <= 1'b1;
          res_q   <= blk_addr;
          state_q <= RESP;
        end
        RESP: begin
          rr_q    <= id_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM controls decode straight from state; writes are held off while reset is asserted.
  always_comb begin
    bus_io.ram_data             = '0;
    bus_io.ram_data[DATA_W-1]   = (state_q == MARK);
  end

  assign bus_io.ram_address = blk_addr;
  assign bus_io.ram_wren    = resetn &&
                              ((state_q == CLEAR) || (state_q == MARK) || (state_q == FREE_WR));
  assign bus_io.grant       = grant_q;
  assign bus_io.done        = done_q;
  assign bus_io.ok          = ok_q;
  assign bus_io.result_addr = res_q;
  assign bus_io.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_heap_alloc_arbiter.sv
// Scoreboarded bench for heap_alloc_arbiter with a 2-cycle-latency RAM model.
module tb_heap_alloc_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic prefill = 1'b1;

  always #5 clock = ~clock;

  heap_alloc_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  heap_alloc_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_STRIDE(32)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus_io (bus)
  );

  logic [DATA_W-1:0] mem [0:1023];
  logic [ADDR_W-1:0] ram_a1;

  always @(posedge clock) begin
    if (prefill) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '1;
    end else if (bus.ram_wren) begin
      mem[bus.ram_address] <= bus.ram_data;
    end
    ram_a1    <= bus.ram_address;
    bus.ram_q <= mem[ram_a1];
  end

  typedef struct {
    logic [NUM_REQ-1:0] grant;
    logic               ok;
    logic [ADDR_W-1:0]  addr;
    int                 lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic fail_msg(input string name, input string detail);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Monitor: latency is measured from the last idle cycle (the accepting one) to done.
  initial begin
    int   cyc;
    int   last_idle;
    exp_t e;
    cyc = 0;
    last_idle = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (bus.ram_wren) wr_cnt++;
      if (!bus.busy) last_idle = cyc;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          fail_msg("unexpected_done", $sformatf("grant=%b addr=%0d with no pending request",
                                                bus.grant, bus.result_addr));
        end else begin
          e = exp_q.pop_front();
          check("resp_grant", 32'(bus.grant), 32'(e.grant));
          check("resp_ok", 32'(bus.ok), 32'(e.ok));
          check("resp_addr", 32'(bus.result_addr), 32'(e.addr));
          check("resp_latency", 32'(cyc - last_idle), 32'(e.lat));
        end
      end else if (bus.grant != '0) begin
        fail_msg("grant_without_done", $sformatf("grant=%b, expected 0", bus.grant));
      end
    end
  end

  // Raise a request at the current negedge and hold it until its grant is seen.
  task automatic request(input int c, input bit is_alloc, input logic [ADDR_W-1:0] addr);
    int n;
    if (is_alloc) begin
      bus.alloc_req[c] = 1'b1;
    end else begin
      bus.free_addr[c*ADDR_W +: ADDR_W] = addr;
      bus.free_req[c] = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.grant[c] && n < 300);
    if (!bus.grant[c]) fail_msg("grant_timeout", $sformatf("client %0d: no grant in 300 cycles", c));
    bus.alloc_req[c] = 1'b0;
    bus.free_req[c]  = 1'b0;
  endtask

  task automatic push_exp(input int c, input bit ok, input logic [ADDR_W-1:0] addr, input int lat);
    exp_t e;
    e.grant = NUM_REQ'(1) << c;
    e.ok    = ok;
    e.addr  = addr;
    e.lat   = lat;
    exp_q.push_back(e);
  endtask

  task automatic do_alloc(input int c, input logic [ADDR_W-1:0] addr, input bit ok, input int lat);
    push_exp(c, ok, addr, lat);
    request(c, 1'b1, '0);
  endtask

  task automatic do_free(input int c, input logic [ADDR_W-1:0] faddr, input bit ok,
                         input logic [ADDR_W-1:0] addr, input int lat);
    push_exp(c, ok, addr, lat);
    request(c, 1'b0, faddr);
  endtask

  task automatic check_clear(input string name);
    int busy_cnt;
    int bad;
    busy_cnt = 0;
    for (int i = 0; i < 31; i++) begin
      if (bus.busy) busy_cnt++;
      @(negedge clock);
    end
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd31);
    check({name, "_idle_after"}, 32'(bus.busy), 32'd0);
    bad = 0;
    for (int k = 1; k < 32; k++) if (mem[k*32] !== 32'h0) bad++;
    check({name, "_headers_nonzero"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gd_cnt;
    int w0;
    int n;
    bus.alloc_req = '0;
    bus.free_req  = '0;
    bus.free_addr = '0;

    repeat (3) @(negedge clock);
    prefill = 1'b0;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ok", 32'(bus.ok), 32'd0);
    check("rst_wren", 32'(bus.ram_wren), 32'd0);
    check("rst_result", 32'(bus.result_addr), 32'd0);

    resetn = 1'b1;
    check_clear("clear");
    check("block0_untouched", mem[0], 32'hFFFF_FFFF);
    check("body_untouched", mem[33], 32'hFFFF_FFFF);

    do_alloc(0, 10'd32, 1'b1, 5);
    do_alloc(0, 10'd64, 1'b1, 8);
    do_alloc(0, 10'd96, 1'b1, 11);
    check("hdr32_marked", mem[32], 32'h8000_0000);

    do_free(0, 10'd32, 1'b1, 10'd32, 5);
    do_free(0, 10'd64, 1'b1, 10'd64, 5);
    do_free(0, 10'd96, 1'b1, 10'd96, 5);

    // Both clients together after a grant to client 0: client 1 wins first.
    push_exp(1, 1'b1, 10'd32, 5);
    push_exp(0, 1'b1, 10'd64, 8);
    fork
      request(1, 1'b1, '0);
      request(0, 1'b1, '0);
    join

    for (int k = 3; k < 32; k++) do_alloc(0, ADDR_W'(k*32), 1'b1, 3*k + 2);
    w0 = wr_cnt;
    do_alloc(0, 10'd0, 1'b0, 94);
    check("full_no_write", 32'(wr_cnt - w0), 32'd0);

    do_free(1, 10'd64, 1'b1, 10'd64, 5);
    check("hdr64_cleared", mem[64], 32'h0);
    do_free(1, 10'd64, 1'b0, 10'd0, 4);
    do_free(0, 10'd65, 1'b0, 10'd0, 1);
    do_free(1, 10'd0, 1'b0, 10'd0, 1);
    do_free(0, 10'd16, 1'b0, 10'd0, 1);
    do_free(0, 10'd992, 1'b1, 10'd992, 5);
    do_alloc(1, 10'd64, 1'b1, 8);
    do_alloc(0, 10'd992, 1'b1, 95);

    // Abort an alloc in SCAN_WAIT with block 2 free.
    do_free(1, 10'd64, 1'b1, 10'd64, 5);
    bus.alloc_req[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.busy && n < 50);
    if (!bus.busy) fail_msg("abort_setup", "alloc was never accepted");
    @(negedge clock);
    resetn = 1'b0;
    gd_cnt = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.done || bus.grant != '0) gd_cnt++;
    end
    bus.alloc_req[0] = 1'b0;
    check("abort_hdr64_untouched", mem[64], 32'h0);
    resetn = 1'b1;
    check_clear("reclear");
    check("abort_no_response", 32'(gd_cnt), 32'd0);
    do_alloc(0, 10'd32, 1'b1, 5);

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
